// File: rtl/count_bcd_converter_pkg.sv
// Shared types and sizes for the 8-bit binary to 3-digit BCD converter.
package count_bcd_converter_pkg;

  localparam int BIN_W   = 8;
  localparam int DIGITS  = 3;
  localparam int DIGIT_W = 4;
  localparam int BCD_W   = 12;
  localparam int ITER_W  = 3;

  localparam logic [ITER_W-1:0] ITER_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import count_bcd_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/count_bcd_converter.sv
// Sequential shift-and-add-3 converter: one sample every 10 cycles, result 8 cycles after capture.
module count_bcd_converter
  import count_bcd_converter_pkg::*;
#(
  parameter int CHANGE_ONLY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] count_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BCD_W-1:0] bcd_out,
  output logic             out_valid
);

  state_e            state;
  state_e            state_nxt;
  logic [BIN_W-1:0]  shift_reg;
  logic [BIN_W-1:0]  shift_nxt;
  logic [BIN_W-1:0]  last_val;
  logic [BCD_W-1:0]  work;
  logic [BCD_W-1:0]  work_adj;
  logic [BCD_W-1:0]  work_nxt;
  logic [ITER_W-1:0] iter;
  logic              hist_valid;
  logic              accept;
  logic              repeat_hit;
  logic              start;
  logic              last_iter;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit_in  (work[DIGIT_W*d +: DIGIT_W]),
      .digit_out (work_adj[DIGIT_W*d +: DIGIT_W])
    );
  end

  assign {work_nxt, shift_nxt} = {work_adj, shift_reg} << 1;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  // A repeated value is still consumed (handshake completes) but no conversion starts.
  assign repeat_hit = (CHANGE_ONLY != 0) && hist_valid && (count_in == last_val);
  assign start      = accept && !repeat_hit;
  assign last_iter  = (iter == ITER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      work       <= '0;
      iter       <= '0;
      bcd_out    <= '0;
      last_val   <= '0;
      hist_valid <= 1'b0;
    end else if (start) begin
      shift_reg  <= count_in;
      work       <= '0;
      iter       <= '0;
      last_val   <= count_in;
      hist_valid <= 1'b1;
    end else if (state == SHIFT) begin
      shift_reg <= shift_nxt;
      work      <= work_nxt;
      iter      <= iter + 3'd1;
      if (last_iter) begin
        bcd_out <= work_nxt;
      end
    end
  end

endmodule

// File: tb/tb_count_bcd_converter.sv
// Bench for count_bcd_converter: one instance per CHANGE_ONLY setting, arithmetic BCD reference.
module tb_count_bcd_converter;

  logic        clk;
  logic        rst;
  logic [7:0]  cin;
  logic        iv;
  logic        sel;
  logic        iv0, iv1;
  logic        rdy0, rdy1, ov0, ov1;
  logic [11:0] bcd0, bcd1;
  logic        cur_rdy, cur_ov;
  logic [11:0] cur_bcd;

  int checks = 0;
  int errors = 0;

  bit         hist1;
  logic [7:0] last1;

  assign iv0     = iv & ~sel;
  assign iv1     = iv & sel;
  assign cur_rdy = sel ? rdy1 : rdy0;
  assign cur_ov  = sel ? ov1 : ov0;
  assign cur_bcd = sel ? bcd1 : bcd0;

  count_bcd_converter #(.CHANGE_ONLY(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .count_in  (cin),
    .in_valid  (iv0),
    .in_ready  (rdy0),
    .bcd_out   (bcd0),
    .out_valid (ov0)
  );

  count_bcd_converter #(.CHANGE_ONLY(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .count_in  (cin),
    .in_valid  (iv1),
    .in_ready  (rdy1),
    .bcd_out   (bcd1),
    .out_valid (ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] bcd_ref(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; offers v for one edge, then watches E1..E9.
  task automatic run_conv(input logic [7:0] v, input bit exp_conv);
    logic [11:0] prev, exp_bcd, seen;
    int pulses, pos;
    prev    = cur_bcd;
    exp_bcd = exp_conv ? bcd_ref(int'(v)) : prev;
    check("rdy_idle", 32'(cur_rdy), 32'd1);
    cin = v;
    iv  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    check("rdy_after_capture", 32'(cur_rdy), 32'(!exp_conv));
    pulses = 0;
    pos    = 0;
    seen   = cur_bcd;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (cur_ov) begin
        pulses++;
        pos  = k;
        seen = cur_bcd;
      end
      if (exp_conv && k < 9) begin
        iv  = 1'($urandom_range(0, 1));
        cin = 8'($urandom);
      end else begin
        iv = 1'b0;
      end
    end
    if (exp_conv) begin
      check("ov_pulses", 32'(pulses), 32'd1);
      check("ov_latency", 32'(pos), 32'd8);
      check("bcd_value", 32'(seen), 32'(exp_bcd));
      check("digit_le9", 32'(seen[11:8] <= 4'd9 && seen[7:4] <= 4'd9 && seen[3:0] <= 4'd9), 32'd1);
    end else begin
      check("ov_suppressed", 32'(pulses), 32'd0);
    end
    check("bcd_hold", 32'(cur_bcd), 32'(exp_bcd));
    check("rdy_end", 32'(cur_rdy), 32'd1);
  endtask

  task automatic run_co(input logic [7:0] v);
    bit exp_conv;
    exp_conv = !hist1 || (v != last1);
    run_conv(v, exp_conv);
    if (exp_conv) begin
      hist1 = 1'b1;
      last1 = v;
    end
  endtask

  initial begin
    logic [7:0] co_seq [6];
    bit         exp_ov;
    int         ov_seen;
    co_seq = '{8'd0, 8'd42, 8'd42, 8'd43, 8'd43, 8'd42};
    rst   = 1'b1;
    iv    = 1'b0;
    cin   = 8'd0;
    sel   = 1'b0;
    hist1 = 1'b0;
    last1 = 8'd0;

    // Reset state of both instances
    repeat (2) @(negedge clk);
    check("rst_ov0", 32'(ov0), 32'd0);
    check("rst_bcd0", 32'(bcd0), 32'h000);
    check("rst_rdy0", 32'(rdy0), 32'd1);
    check("rst_ov1", 32'(ov1), 32'd0);
    check("rst_bcd1", 32'(bcd1), 32'h000);
    check("rst_rdy1", 32'(rdy1), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // First accept on the first edge after reset release, then corner values
    run_conv(8'd0, 1'b1);
    run_conv(8'd255, 1'b1);
    run_conv(8'd99, 1'b1);
    run_conv(8'd100, 1'b1);

    // in_valid held with a value stepping every cycle: captures every 10 cycles
    iv  = 1'b1;
    cin = 8'd10;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_ov = ((c % 10) == 8);
      check("b2b_ov", 32'(cur_ov), 32'(exp_ov));
      if (exp_ov) check("b2b_bcd", 32'(cur_bcd), 32'(bcd_ref(10 + c - 8)));
      cin = 8'(11 + c);
    end
    iv = 1'b0;

    // Full sweep of the input range
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), 1'b1);
    end

    // Change-only instance: directed sequence then random values with frequent repeats
    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_co(co_seq[i]);
    for (int i = 0; i < 40; i++) run_co(8'($urandom_range(40, 43)));

    // Reset in the middle of a conversion
    sel = 1'b0;
    @(negedge clk);
    cin = 8'd200;
    iv  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_ov", 32'(ov0), 32'd0);
    check("abort_bcd", 32'(bcd0), 32'h000);
    check("abort_rdy", 32'(rdy0), 32'd1);
    iv  = 1'b1;
    cin = 8'd77;
    ov_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ov0 || bcd0 != 12'h000 || !rdy0) ov_seen++;
    end
    check("abort_held", 32'(ov_seen), 32'd0);
    hist1 = 1'b0;
    iv    = 1'b0;
    rst   = 1'b0;
    run_conv(8'd7, 1'b1);

    // Change-only history is cleared by reset
    sel = 1'b1;
    @(negedge clk);
    run_co(last1);
    run_co(last1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
